// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink monitor and the LED_blinker benches:
// FSM state encoding and elaboration-time period/width helpers.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  function automatic int unsigned exp_cycles(input int unsigned clk_in,
                                             input int unsigned freq_out);
    return clk_in / freq_out;
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned exp_c);
    return 2 * exp_c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned exp_c);
    return $clog2(2 * exp_c + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with registered rising-edge strobe.
// Latency from i_d rising to o_rise is SYNC_STAGES+1 cycles.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      prev_q <= sync_q[SYNC_STAGES-1];
      o_rise <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/led_blink_monitor.sv
// Receive-side checker for the LED blinker: measures rise-to-rise period,
// flags out-of-tolerance periods and a stuck line, and tracks lock.
module led_blink_monitor
  import led_blink_pkg::*;
#(
  parameter  int unsigned CLK_IN      = 300,
  parameter  int unsigned FREQ_OUT    = 5,
  parameter  int unsigned TOL         = 2,
  parameter  int unsigned LOCK_COUNT  = 3,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned CNT_W       = cnt_width(exp_cycles(CLK_IN, FREQ_OUT))
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_blink,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_stuck
);

  localparam int unsigned EXP     = exp_cycles(CLK_IN, FREQ_OUT);
  localparam int unsigned TIMEOUT = timeout_cycles(EXP);
  localparam int unsigned GOOD_W  = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  LO_C   = CNT_W'(EXP - TOL);
  localparam logic [CNT_W-1:0]  HI_C   = CNT_W'(EXP + TOL);
  localparam logic [CNT_W-1:0]  TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] GONE_C = GOOD_W'(1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [GOOD_W-1:0]   good_cnt, good_d;
  logic [CNT_W-1:0]    period_d;
  logic                valid_d, locked_d, err_d, stuck_d;
  logic                rise, in_tol;
  logic                unused_blink_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_blink),
    .o_q       (unused_blink_q),
    .o_rise    (rise)
  );

  assign in_tol = (cnt >= LO_C) && (cnt <= HI_C);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      good_cnt       <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_locked       <= 1'b0;
      o_err          <= 1'b0;
      o_stuck        <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      good_cnt       <= good_d;
      o_period       <= period_d;
      o_period_valid <= valid_d;
      o_locked       <= locked_d;
      o_err          <= err_d;
      o_stuck        <= stuck_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    good_d   = good_cnt;
    period_d = o_period;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = o_locked;
    stuck_d  = o_stuck;

    if (!i_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
      stuck_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
          stuck_d  = 1'b0;
          state_d  = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = ONE_C;
            stuck_d = 1'b0;
          end else if (cnt == TO_C) begin
            stuck_d = 1'b1;
          end else begin
            cnt_d = cnt + ONE_C;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle is still a measurement (and a bad one).
          if (rise) begin
            period_d = cnt;
            valid_d  = 1'b1;
            cnt_d    = ONE_C;
            if (in_tol) begin
              good_d = (good_cnt == LOCK_C) ? good_cnt : good_cnt + GONE_C;
              if (good_d == LOCK_C) locked_d = 1'b1;
            end else begin
              good_d   = '0;
              locked_d = 1'b0;
              err_d    = 1'b1;
            end
          end else if (cnt == TO_C) begin
            state_d  = ARM;
            good_d   = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
            stuck_d  = 1'b1;
          end else begin
            cnt_d = cnt + ONE_C;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_monitor.sv
// Directed bench for led_blink_monitor: timestamp-based reference model
// compared every cycle, plus literal checks on key events.
module tb_led_blink_monitor;

  localparam int unsigned EXP     = 60;
  localparam int unsigned TOL     = 2;
  localparam int unsigned TIMEOUT = 120;
  localparam int unsigned LOCK    = 3;
  localparam int unsigned CNT_W   = $clog2(2 * EXP + 1);

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_en;
  logic             i_blink;
  logic [CNT_W-1:0] o_period;
  logic             o_period_valid;
  logic             o_locked;
  logic             o_err;
  logic             o_stuck;

  led_blink_monitor #(
    .CLK_IN      (300),
    .FREQ_OUT    (5),
    .TOL         (TOL),
    .LOCK_COUNT  (LOCK),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_en           (i_en),
    .i_blink        (i_blink),
    .o_period       (o_period),
    .o_period_valid (o_period_valid),
    .o_locked       (o_locked),
    .o_err          (o_err),
    .o_stuck        (o_stuck)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode, timestamps of the last seen rise and of arming.
  typedef enum {M_OFF, M_WAIT, M_MEAS} mmode_t;
  mmode_t mode;
  int     now, last_rise, arm_start, good_run;
  int     m_period;
  bit     m_valid, m_err, m_stuck;
  bit     s1, s2, s3, s4;

  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, err_period = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mode = M_OFF; now = 0; last_rise = 0; arm_start = 0; good_run = 0;
    m_period = 0; m_valid = 0; m_err = 0; m_stuck = 0;
    s1 = 0; s2 = 0; s3 = 0; s4 = 0;
  endtask

  // Called at each rising edge with the inputs as the DUT samples them.
  task automatic model_step();
    bit seen;
    int gap;
    if (!i_reset_n) begin
      model_reset();
      return;
    end
    now++;
    seen = s3 && !s4;
    s4 = s3; s3 = s2; s2 = s1; s1 = i_blink;
    m_valid = 0;
    m_err   = 0;
    if (!i_en) begin
      mode = M_OFF; good_run = 0; m_stuck = 0;
    end else begin
      case (mode)
        M_OFF: begin
          mode = M_WAIT; arm_start = now; good_run = 0; m_stuck = 0;
        end
        M_WAIT: begin
          if (seen) begin
            mode = M_MEAS; last_rise = now; m_stuck = 0;
          end else if (now - arm_start > int'(TIMEOUT)) begin
            m_stuck = 1;
          end
        end
        default: begin
          gap = now - last_rise;
          if (seen) begin
            m_period  = gap;
            m_valid   = 1;
            last_rise = now;
            if (gap >= int'(EXP - TOL) && gap <= int'(EXP + TOL)) good_run++;
            else begin
              good_run = 0; m_err = 1;
            end
          end else if (gap == int'(TIMEOUT)) begin
            m_err = 1; m_stuck = 1; good_run = 0;
            mode = M_WAIT; arm_start = now;
          end
        end
      endcase
    end
  endtask

  task automatic compare_cycle();
    chk("o_period",       int'(o_period), m_period);
    chk("o_period_valid", int'(o_period_valid), int'(m_valid));
    chk("o_locked",       int'(o_locked), (good_run >= int'(LOCK)) ? 1 : 0);
    chk("o_err",          int'(o_err), int'(m_err));
    chk("o_stuck",        int'(o_stuck), int'(m_stuck));
    if (o_period_valid) valid_cnt++;
    if (o_err) err_cnt++;
    if (o_period_valid && o_err) begin
      both_cnt++;
      err_period = int'(o_period);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge i_clk);
      compare_cycle();
      @(posedge i_clk);
      model_step();
      #1;
    end
  endtask

  task automatic per(input int unsigned p);
    i_blink = 1'b1;
    tick(p / 2);
    i_blink = 1'b0;
    tick(p - p / 2);
  endtask

  int v0, e0, b0;

  initial begin
    model_reset();
    i_reset_n = 1'b0;
    i_en      = 1'b0;
    i_blink   = 1'b0;

    // 1: reset with a toggling line, then release with monitor disabled
    for (int i = 0; i < 6; i++) begin
      i_blink = ~i_blink;
      tick(1);
    end
    chk("reset_outputs", int'({o_period, o_period_valid, o_locked, o_err, o_stuck}), 0);
    i_reset_n = 1'b1;
    i_blink   = 1'b0;
    tick(10);
    chk("disabled_outputs", int'({o_period, o_period_valid, o_locked, o_err, o_stuck}), 0);

    // 2: nominal 60-cycle blink, lock on the 4th rise
    i_en = 1'b1;
    tick(5);
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) per(60);
    chk("no_lock_before_4th_rise", int'(o_locked), 0);
    per(60);
    chk("lock_after_4th_rise", int'(o_locked), 1);
    per(60);
    per(60);
    chk("nominal_period", int'(o_period), 60);
    chk("nominal_valid_count", valid_cnt - v0, 5);
    chk("nominal_no_err", err_cnt - e0, 0);

    // 3: tolerance edges accepted, 63 rejected, relock after three good
    b0 = both_cnt;
    per(58);
    per(62);
    per(63);
    chk("tol_edges_keep_lock", int'(o_locked), 1);
    chk("tol_edges_no_err", err_cnt - e0, 0);
    per(60);
    chk("bad_err_with_valid", both_cnt - b0, 1);
    chk("bad_period_value", err_period, 63);
    chk("bad_drops_lock", int'(o_locked), 0);
    per(60);
    per(60);
    chk("relock_not_yet", int'(o_locked), 0);
    per(60);
    chk("relock", int'(o_locked), 1);

    // 4: line held low until timeout, then resumes
    e0 = err_cnt;
    tick(60);
    chk("stuck_not_before_timeout", int'(o_stuck), 0);
    tick(10);
    chk("stuck_after_timeout", int'(o_stuck), 1);
    chk("stuck_drops_lock", int'(o_locked), 0);
    chk("stuck_single_err", err_cnt - e0, 1);
    tick(100);
    chk("stuck_no_repeat_err", err_cnt - e0, 1);
    chk("stuck_held", int'(o_stuck), 1);
    v0 = valid_cnt;
    per(60);
    chk("stuck_clears_on_rise", int'(o_stuck), 0);
    chk("first_edge_unmeasured", valid_cnt - v0, 0);
    for (int i = 0; i < 3; i++) per(60);
    chk("lock_after_resume", int'(o_locked), 1);

    // 5: single-cycle glitch 20 cycles into a period
    b0 = both_cnt;
    i_blink = 1'b1; tick(10);
    i_blink = 1'b0; tick(10);
    i_blink = 1'b1; tick(1);
    i_blink = 1'b0; tick(5);
    chk("glitch_err_with_valid", both_cnt - b0, 1);
    chk("glitch_period", err_period, 20);
    chk("glitch_drops_lock", int'(o_locked), 0);
    tick(35);

    // 6: disable pulse mid-measure, then asynchronous reset
    for (int i = 0; i < 4; i++) per(60);
    chk("lock_before_disable", int'(o_locked), 1);
    i_blink = 1'b1;
    tick(10);
    v0 = valid_cnt; e0 = err_cnt;
    i_en = 1'b0;
    tick(1);
    i_en = 1'b1;
    tick(3);
    chk("disable_clears_lock", int'(o_locked), 0);
    chk("disable_no_valid", valid_cnt - v0, 0);
    chk("disable_no_err", err_cnt - e0, 0);
    i_blink = 1'b0;
    tick(50);
    per(60);
    chk("reenable_first_edge_unmeasured", valid_cnt - v0, 0);
    for (int i = 0; i < 3; i++) per(60);
    chk("lock_before_reset", int'(o_locked), 1);
    #2;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_period", int'(o_period), 0);
    chk("async_reset_valid", int'(o_period_valid), 0);
    chk("async_reset_locked", int'(o_locked), 0);
    chk("async_reset_err", int'(o_err), 0);
    chk("async_reset_stuck", int'(o_stuck), 0);
    tick(3);
    i_reset_n = 1'b1;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
